// File: rtl/alu_op_sequencer.sv
// Serialized ALU issue controller: result ALU_LAT+1 cycles (DIVU DIV_CYCLES+1) after accept; in_ready low while busy, RESP held until out_ready.
// Optional ALU_SEQ_DIVZERO_CHK_EN traps DIVU by zero before issue (all-ones result, err_divzero).
module alu_op_sequencer #(
  parameter int          ALU_LAT    = 1,
  parameter int          DIV_CYCLES = 32,
  parameter logic [5:0]  IDLE_FUNCT = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [5:0]  in_funct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err_illegal,
  output logic        err_divzero,
  output logic        busy,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_dataOut
);

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_DIVU = 6'h1B;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;

  localparam int MAX_LAT = (DIV_CYCLES > ALU_LAT) ? DIV_CYCLES : ALU_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [5:0]         funct_q, funct_d;
  logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [5:0]         alu_sig_q, alu_sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               err_ill_q, err_ill_d, err_dz_q, err_dz_d;
  logic               legal;

  always_comb begin
    case (funct_q)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SRL, F_DIVU, F_MFHI, F_MFLO: legal = 1'b1;
      default:                                                        legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    funct_d    = funct_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sig_d  = alu_sig_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_ill_d  = err_ill_q;
    err_dz_d   = err_dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = in_a;
          b_d       = in_b;
          funct_d   = in_funct;
          err_ill_d = 1'b0;
          err_dz_d  = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Rejected ops bypass the ALU entirely so its inputs and Hi/Lo are untouched.
        if (!legal) begin
          out_data_d = 32'h0;
          err_ill_d  = 1'b1;
          state_d    = RESP;
        end
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        else if (funct_q == F_DIVU && b_q == 32'h0) begin
          out_data_d = 32'hFFFF_FFFF;
          err_dz_d   = 1'b1;
          state_d    = RESP;
        end
`endif
        else begin
          alu_a_d   = a_q;
          alu_b_d   = b_q;
          alu_sig_d = funct_q;
          cnt_d     = (funct_q == F_DIVU) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(ALU_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          out_data_d = (funct_q == F_DIVU) ? 32'h0 : alu_dataOut;
          alu_sig_d  = IDLE_FUNCT;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      funct_q    <= 6'h0;
      alu_a_q    <= 32'h0;
      alu_b_q    <= 32'h0;
      alu_sig_q  <= IDLE_FUNCT;
      cnt_q      <= '0;
      out_data_q <= 32'h0;
      err_ill_q  <= 1'b0;
      err_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      funct_q    <= funct_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sig_q  <= alu_sig_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      err_ill_q  <= err_ill_d;
      err_dz_q   <= err_dz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == RESP);
  assign out_data    = out_data_q;
  assign err_illegal = err_ill_q;
  assign err_divzero = err_dz_q;
  assign alu_dataA   = alu_a_q;
  assign alu_dataB   = alu_b_q;
  assign alu_signal  = alu_sig_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue controller placed directly upstream of the ALU top level (ALU + divider + Hi/Lo + shifter + output mux). It accepts one operation at a time over a valid/ready handshake and drives the ALU's `dataA`, `dataB` and `signal` inputs from registers. It holds those inputs stable for the operation's fixed latency, including the multi-cycle divide, then captures `dataOut` and returns it over a second valid/ready handshake. Operations are strictly serialized, so MFHI/MFLO always observe a completed DIVU.

## Interface
Parameters:
- `ALU_LAT`, default 1: cycles from registered ALU inputs to a valid `dataOut` for ADD, SUB, AND, OR, SLT, SRL, MFHI and MFLO.
- `DIV_CYCLES`, default 32: cycles from registered ALU inputs to Hi/Lo updated for DIVU.
- `IDLE_FUNCT`, default 6'h3F: code driven on `alu_signal` when no operation is in flight.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_a`  in  32  operand A.
- `in_b`  in  32  operand B / shift amount.
- `in_funct`  in  6  operation code.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  response consumed when `out_valid & out_ready`.
- `out_data`  out  32  result.
- `err_illegal`  out  1  response is for an unsupported funct.
- `err_divzero`  out  1  response is for DIVU with `in_b == 0` (see Configuration).
- `busy`  out  1  state ≠ IDLE.
- `alu_dataA`  out  32  to ALU `dataA`.
- `alu_dataB`  out  32  to ALU `dataB`.
- `alu_signal`  out  6  to ALU `signal`.
- `alu_dataOut`  in  32  from ALU `dataOut`.

## Operation
- Supported funct codes: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A, SRL 6'h02, DIVU 6'h1B, MFHI 6'h10, MFLO 6'h12. Every other code is illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `in_ready` = 1.
  - On accept with a legal code: latch operands and funct, go to ISSUE.
  - On accept with an illegal code: go to RESP with `out_data` = 0 and `err_illegal` = 1. Nothing is driven to the ALU.
- ISSUE (1 cycle):
  - `alu_*` registers hold the latched operands and funct.
  - Load the down-counter with `DIV_CYCLES-1` for DIVU, else `ALU_LAT-1`.
  - Go to WAIT.
- WAIT:
  - Decrement the counter; `alu_*` stay stable.
  - At count 0: capture `alu_dataOut` into `out_data`, except for DIVU, where `out_data` = 0 (completion acknowledge only).
  - Return `alu_signal` to `IDLE_FUNCT` and go to RESP.
- RESP:
  - `out_valid` = 1.
  - `out_data`, `err_illegal` and `err_divzero` are held until `out_ready`.
  - On the response handshake go to IDLE.
- `in_ready` is 0 in every state except IDLE. Only one operation is outstanding at any time.
- `alu_dataA` and `alu_dataB` keep their last value while idle. Only `alu_signal` is parked at `IDLE_FUNCT`.

## Timing
- Reset values: `in_ready` = 1 and `busy` = 0 once reset deasserts. `out_valid` = 0, `out_data` = 0, both error flags = 0, `alu_dataA` = `alu_dataB` = 0, `alu_signal` = `IDLE_FUNCT`. State = IDLE, counter = 0.
- Request accepted at edge k:
  - `alu_*` are valid from edge k+1.
  - `out_valid` rises at edge k+1+`ALU_LAT` for ALU ops, or k+1+`DIV_CYCLES` for DIVU.
  - `out_valid` rises at edge k+1 for illegal codes and for a trapped divide-by-zero.
- The response handshake at edge m returns the FSM to IDLE; `in_ready` is high from edge m.
- Back-to-back throughput with `out_ready` held at 1 is one op per `ALU_LAT`+3 cycles.
- `out_ready` held low: RESP persists indefinitely with all outputs stable.
- `in_valid` while busy: ignored. The requester must hold its request until `in_ready`.
- `reset` asserted mid-operation: every output immediately takes its reset value and any in-flight op is dropped. The downstream ALU, divider and Hi/Lo are reset by their own reset; the sequencer makes no attempt to reconcile with them.

## Configuration
- `ALU_SEQ_DIVZERO_CHK_EN` defined:
  - DIVU with `in_b == 0` is never issued to the ALU, so Hi/Lo stay unchanged.
  - It goes straight to RESP with `out_data` = 32'hFFFF_FFFF and `err_divzero` = 1.
- `ALU_SEQ_DIVZERO_CHK_EN` undefined:
  - DIVU with `in_b == 0` is issued normally.
  - `err_divzero` is tied to 0.

## Test plan
- ADD with `in_a` = 5, `in_b` = 7, `out_ready` = 1 → `out_valid` at k+2, `out_data` = 12; `in_ready` returns the same cycle as the handshake.
- DIVU 100/7, then MFHI, then MFLO → DIVU response at k+33 with `out_data` = 0; MFHI returns 2; MFLO returns 14.
- `in_funct` = 6'h3E → `out_valid` at k+1, `err_illegal` = 1, `out_data` = 0; `alu_signal` stays `IDLE_FUNCT` throughout.
- SUB 3-5 with `out_ready` = 0 for 10 cycles → `out_valid` and `out_data` = 32'hFFFF_FFFE held stable, `in_ready` = 0, new requests ignored.
- `reset` pulsed low 10 cycles into a DIVU → `out_valid` = 0 and `busy` = 0 immediately; `in_ready` = 1 after release; the next ADD completes normally.
- DIVU with `in_b` = 0 → with the macro: k+1, `err_divzero` = 1, `out_data` = 32'hFFFF_FFFF, a following MFLO returns the prior Lo. Without the macro: response at k+33 with `err_divzero` = 0.
